// File: rtl/in_dma_seq_pkg.sv
// Shared definitions for the input-DMA sequencer: FSM state encoding and AXI/boundary constants.
package in_dma_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitBuf,
    StAddr,
    StData,
    StDone
  } state_e;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam int unsigned BOUNDARY_BYTES = 4096;

endpackage

// File: rtl/in_dma_seq_burst_calc.sv
// Combinational burst sizer for the input-DMA sequencer.
// Picks the largest INCR burst starting at the current address that respects the remaining beat
// count, the MAX_BURST cap and the 4 KB AXI boundary.
// Ports:
//   addr_lo_i  in   12  low 12 bits of the current (BYTES-aligned) byte address
//   remain_i   in   16  beats still to fetch
//   blen_o     out  17  beats in the next burst (zero only when remain_i is zero)
module in_dma_seq_burst_calc
  import in_dma_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic [11:0] addr_lo_i,
  input  logic [15:0] remain_i,
  output logic [16:0] blen_o
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;

  logic [16:0] to4k;
  logic [16:0] remain_ext;
  logic [16:0] max_ext;
  logic [16:0] capped;

  always_comb begin
    // Beats left before the next 4 KB line; a full page when sitting exactly on the line.
    to4k       = (17'(BOUNDARY_BYTES) - {5'b0, addr_lo_i}) / 17'(BYTES);
    remain_ext = {1'b0, remain_i};
    max_ext    = 17'(MAX_BURST);
    capped     = (remain_ext < max_ext) ? remain_ext : max_ext;
    blen_o     = (capped < to4k) ? capped : to4k;
  end

endmodule

// File: rtl/in_dma_seq.sv
// Input-DMA sequencer.
// Accepts one transfer command (base address, beat count), splits it into AXI INCR bursts of at
// most MAX_BURST beats that never cross a 4 KB boundary, and hands each burst to in_dma via
// dma_addr/dma_burst_len/dma_start. Burst completion is detected by snooping in_dma's AR and R
// handshakes. A burst is only issued once the input buffer reports room for all of it.
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset (shared with in_dma)
//   cmd_valid/cmd_ready       command handshake; ready only while idle
//   cmd_addr, cmd_beats       start byte address (BYTES-aligned) and total beats (0 allowed)
//   buf_free                  free beat slots in the input buffer
//   dma_addr, dma_burst_len   burst start address and beats-1 towards in_dma
//   dma_start                 one-cycle pulse per burst
//   arvalid/arready           snooped AR handshake
//   rid, rvalid/rready        snooped R handshake; only beats with rid == ID are counted
//   busy                      high from command accept until the done pulse
//   done                      one-cycle pulse when the command has completed
//   err                       one-cycle pulse when a misaligned command is rejected
module in_dma_seq
  import in_dma_seq_pkg::*;
#(
  parameter int unsigned         ADDR_WIDTH = 32,
  parameter int unsigned         DATA_WIDTH = 256,
  parameter int unsigned         ID_WIDTH   = 8,
  parameter logic [ID_WIDTH-1:0] ID         = 8'h80,
  parameter int unsigned         MAX_BURST  = 16,
  parameter int unsigned         FREE_W     = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [15:0]           cmd_beats,
  input  logic [FREE_W-1:0]     buf_free,
  output logic [ADDR_WIDTH-1:0] dma_addr,
  output logic [3:0]            dma_burst_len,
  output logic                  dma_start,
  input  logic                  arvalid,
  input  logic                  arready,
  input  logic [ID_WIDTH-1:0]   rid,
  input  logic                  rvalid,
  input  logic                  rready,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   cur_addr_q;
  logic [15:0]             remain_q;
  logic [4:0]              cur_len_q;
  logic [4:0]              beat_cnt_q;
  logic [ADDR_WIDTH-1:0]   dma_addr_q;
  logic [3:0]              dma_len_q;
  logic                    dma_start_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    err_q;

  logic [16:0]             blen;
  logic                    cmd_fire;
  logic                    misaligned;
  logic                    r_hit;
  logic                    last_beat;
  logic                    buf_ok;
  logic [ADDR_WIDTH-1:0]   addr_step;
  logic [15:0]             remain_nxt;

  in_dma_seq_burst_calc #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_BURST  (MAX_BURST)
  ) u_burst_calc (
    .addr_lo_i (cur_addr_q[11:0]),
    .remain_i  (remain_q),
    .blen_o    (blen)
  );

  // Ready is held off during the done pulse so a new command is seen only the cycle after it.
  assign cmd_ready = (state_q == StIdle) && !done_q;

  always_comb begin
    cmd_fire   = cmd_valid && cmd_ready;
    misaligned = |cmd_addr[OFF_W-1:0];
    r_hit      = rvalid && rready && (rid == ID);
    last_beat  = r_hit && (beat_cnt_q == (cur_len_q - 5'd1));
    // All-or-nothing credit check: partial bursts are never issued to fit the buffer.
    buf_ok     = (17'(buf_free) >= blen);
    addr_step  = ADDR_WIDTH'(cur_len_q) << OFF_W;
    remain_nxt = remain_q - 16'(cur_len_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      remain_q    <= '0;
      cur_len_q   <= '0;
      beat_cnt_q  <= '0;
      dma_addr_q  <= '0;
      dma_len_q   <= '0;
      dma_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      dma_start_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cmd_fire) begin
            if (misaligned) begin
              err_q <= 1'b1;
            end else begin
              cur_addr_q <= cmd_addr;
              remain_q   <= cmd_beats;
              busy_q     <= 1'b1;
              state_q    <= (cmd_beats == 16'd0) ? StDone : StWaitBuf;
            end
          end
        end
        StWaitBuf: begin
          if (buf_ok) begin
            dma_addr_q  <= cur_addr_q;
            dma_len_q   <= 4'(blen - 17'd1);
            dma_start_q <= 1'b1;
            cur_len_q   <= 5'(blen);
            state_q     <= StAddr;
          end
        end
        StAddr: begin
          if (arvalid && arready) begin
            beat_cnt_q <= '0;
            state_q    <= StData;
          end
        end
        StData: begin
          if (r_hit) begin
            if (last_beat) begin
              // Address wraps modulo 2^ADDR_WIDTH on purpose.
              cur_addr_q <= cur_addr_q + addr_step;
              remain_q   <= remain_nxt;
              state_q    <= (remain_nxt == 16'd0) ? StDone : StWaitBuf;
            end else begin
              beat_cnt_q <= beat_cnt_q + 5'd1;
            end
          end
        end
        StDone: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign dma_addr      = dma_addr_q;
  assign dma_burst_len = dma_len_q;
  assign dma_start     = dma_start_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

  // Sanity properties on the pulse outputs and the sizer.
  a_start_pulse : assert property (@(posedge clk) disable iff (!rstn) dma_start |=> !dma_start);
  a_done_pulse  : assert property (@(posedge clk) disable iff (!rstn) done |=> !done);
  a_busy_ready  : assert property (@(posedge clk) disable iff (!rstn) busy |-> !cmd_ready);
  a_blen_nz     : assert property (@(posedge clk) disable iff (!rstn)
                                   (state_q == StWaitBuf) |-> (blen != 17'd0));

endmodule
